sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-002 SHALL have port: rst  in  1  synchronous reset, active-high.
REQ-003 SHALL have port: cpu_addr  in  19  mapped RAM address from the memory mapper.
REQ-004 SHALL have port: cpu_oe_n  in  1  CPU RAM select, active-low.
REQ-005 SHALL have port: cpu_we_n  in  1  CPU write strobe, active-low.
REQ-006 SHALL have port: cpu_din  in  8  CPU write data.
REQ-007 SHALL have port: cpu_dout  out  8  last CPU read data.
REQ-008 SHALL have port: cpu_wait_n  out  1  low while a CPU access is pending or in progress.
REQ-009 SHALL have port: vid_req  in  1  video fetch request, level.
REQ-010 SHALL have port: vid_page  in  1  shadow screen select (0 = page 5, 1 = page 7).
REQ-011 SHALL have port: vid_addr  in  14  offset within the screen page.
REQ-012 SHALL have port: vid_ack  out  1  one-cycle pulse, vid_data valid.
REQ-013 SHALL have port: vid_data  out  8  fetched video byte.
REQ-014 SHALL have ports: sram_addr out 19; sram_dq_o out 8; sram_dq_oe out 1; sram_dq_i in 8; sram_we_n out 1.

Function
REQ-015 SHALL register cpu_oe_n and detect its falling edge as a CPU access start; set cpu_pend, latching cpu_addr, cpu_din, and is_write = !cpu_we_n.
REQ-016 SHALL service at most one SRAM operation per CPU falling edge; a new edge while cpu_pend is set SHALL be ignored.
REQ-017 SHALL implement FSM states IDLE, VID_RD, CPU_RD, WR_SETUP, WR_PULSE, WR_HOLD.
REQ-018 In IDLE, if vid_req is asserted and the previous grant was not video or cpu_pend is clear, SHALL go to VID_RD; else if cpu_pend is set, SHALL go to CPU_RD or WR_SETUP.
REQ-019 Arbitration: video has priority, but after any video access with cpu_pend set, the CPU SHALL be served next (strict alternation, no CPU starvation).
REQ-020 VID_RD SHALL last 2 cycles with sram_addr = {2'b00, vid_page ? 3'b111 : 3'b101, vid_addr}; sram_dq_i SHALL be sampled at the end of cycle 2 into vid_data, and vid_ack SHALL pulse on the next cycle.
REQ-021 CPU_RD SHALL last 2 cycles with sram_addr = latched address; data SHALL be sampled into cpu_dout, then cpu_pend SHALL clear.
REQ-022 Write sequencing: WR_SETUP (1 cycle: address and data driven, sram_dq_oe = 1, sram_we_n = 1); WR_PULSE (2 cycles: sram_we_n = 0); WR_HOLD (1 cycle: sram_we_n = 1, data still driven); then sram_dq_oe = 0 and cpu_pend clears.
REQ-023 An operation in progress SHALL never be preempted; vid_req arriving mid-write waits until IDLE.
REQ-024 sram_dq_oe SHALL be 0 in every state except WR_SETUP, WR_PULSE and WR_HOLD; sram_we_n SHALL be 0 only in WR_PULSE.
REQ-025 cpu_dout and vid_data SHALL hold their values until overwritten by the next read of the same kind.
REQ-026 Every state SHALL return to IDLE; worst-case CPU latency from edge to completion SHALL be at most 2 + 1 + 4 = 7 cycles.

Reset
REQ-027 On rst: state = IDLE, cpu_pend = 0, sram_we_n = 1, sram_dq_oe = 0, vid_ack = 0, cpu_dout = 8'h00, vid_data = 8'h00, sram_addr = 0, cpu_wait_n = 1, registered cpu_oe_n = 1.
REQ-028 Reset asserted mid-write SHALL force sram_we_n high and sram_dq_oe low in the cycle following the reset edge; the write is abandoned.

Configuration
REQ-029 Macro CPU_WAIT_EN: when defined, cpu_wait_n SHALL be low from the cycle after the CPU falling edge until the cycle after cpu_pend clears; when undefined, cpu_wait_n SHALL be tied to 1 and all other behaviour SHALL be unchanged.

Verification
REQ-030 CPU read alone: preload SRAM 0x2A05 = 8'h5C, cpu_addr = 19'h02A05, cpu_oe_n falls -> sram_addr = 19'h02A05 for 2 cycles; cpu_dout = 8'h5C; sram_we_n stays 1.
REQ-031 CPU write: cpu_addr = 19'h1C000, cpu_din = 8'hA5, cpu_we_n = 0, cpu_oe_n falls -> 1 setup cycle, sram_we_n low exactly 2 cycles, 1 hold cycle; SRAM[0x1C000] = 8'hA5.
REQ-032 Collision: vid_req = 1, vid_page = 1, vid_addr = 14'h0000, plus CPU read edge in the same cycle -> VID_RD at 19'h1C000 first, vid_ack pulses, then CPU_RD; the order SHALL be video then CPU.
REQ-033 Starvation check: vid_req held high for 200 cycles while the CPU issues reads every 8 cycles -> every CPU read completes within 7 cycles; grants alternate.
REQ-034 Reset mid-write: assert rst during WR_PULSE -> next cycle sram_we_n = 1, sram_dq_oe = 0, state IDLE, cpu_pend = 0.
REQ-035 With CPU_WAIT_EN: cpu_wait_n is low for the whole CPU access and high otherwise; without the macro: cpu_wait_n is constantly 1.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: CPU, video and SRAM signal bundle around the arbiter.
interface sram_arbiter_if;
    logic [18:0] cpu_addr;
    logic        cpu_oe_n;
    logic        cpu_we_n;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        cpu_wait_n;
    logic        vid_req;
    logic        vid_page;
    logic [13:0] vid_addr;
    logic        vid_ack;
    logic [7:0]  vid_data;
    logic [18:0] sram_addr;
    logic [7:0]  sram_dq_o;
    logic        sram_dq_oe;
    logic [7:0]  sram_dq_i;
    logic        sram_we_n;
    modport slave (
        input  cpu_addr, cpu_oe_n, cpu_we_n, cpu_din, vid_req, vid_page, vid_addr, sram_dq_i,
        output cpu_dout, cpu_wait_n, vid_ack, vid_data, sram_addr, sram_dq_o, sram_dq_oe, sram_we_n
    );
    modport master (
        output cpu_addr, cpu_oe_n, cpu_we_n, cpu_din, vid_req, vid_page, vid_addr, sram_dq_i,
        input  cpu_dout, cpu_wait_n, vid_ack, vid_data, sram_addr, sram_dq_o, sram_dq_oe, sram_we_n
    );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one async SRAM between CPU accesses and video fetches with alternating priority.
// Define CPU_WAIT_EN to drive cpu_wait_n low while a CPU access is pending; otherwise it is tied high.
module sram_arbiter (
    input logic clk,
    input logic rst,
    sram_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, VID_RD, CPU_RD, WR_SETUP, WR_PULSE, WR_HOLD} state_t;
    state_t state, state_nx;
    logic oe_q, cpu_pend, is_write, last_vid, cnt, cpu_edge, cpu_done;
    logic [18:0] addr_q;
    logic [7:0] din_q;
    assign cpu_edge = oe_q && !bus.cpu_oe_n;
    assign cpu_done = (state == CPU_RD && cnt) || state == WR_HOLD;
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            oe_q         <= 1'b1;
            cpu_pend     <= 1'b0;
            is_write     <= 1'b0;
            last_vid     <= 1'b0;
            cnt          <= 1'b0;
            addr_q       <= '0;
            din_q        <= '0;
            bus.cpu_dout <= 8'h00;
            bus.vid_data <= 8'h00;
            bus.vid_ack  <= 1'b0;
        end else begin
            state       <= state_nx;
            oe_q        <= bus.cpu_oe_n;
            cnt         <= (state == VID_RD || state == CPU_RD || state == WR_PULSE) && !cnt;
            bus.vid_ack <= state == VID_RD && cnt;
            if (state == VID_RD && cnt)
                bus.vid_data <= bus.sram_dq_i;
            if (state == CPU_RD && cnt)
                bus.cpu_dout <= bus.sram_dq_i;
            if (state == IDLE && state_nx != IDLE)
                last_vid <= state_nx == VID_RD;
            // an edge arriving while an access is outstanding is dropped, never queued
            if (cpu_edge && !cpu_pend) begin
                cpu_pend <= 1'b1;
                addr_q   <= bus.cpu_addr;
                din_q    <= bus.cpu_din;
                is_write <= !bus.cpu_we_n;
            end else if (cpu_done) begin
                cpu_pend <= 1'b0;
            end
        end
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = bus.vid_req && (!last_vid || !cpu_pend) ? VID_RD :
                                 !cpu_pend ? IDLE : is_write ? WR_SETUP : CPU_RD;
            VID_RD,
            CPU_RD:   state_nx = cnt ? IDLE : state;
            WR_SETUP: state_nx = WR_PULSE;
            WR_PULSE: state_nx = cnt ? WR_HOLD : WR_PULSE;
            default:  state_nx = IDLE;
        endcase
        bus.sram_addr  = state == VID_RD ? {2'b00, bus.vid_page ? 3'b111 : 3'b101, bus.vid_addr} :
                         state == IDLE ? 19'd0 : addr_q;
        bus.sram_dq_o  = din_q;
        bus.sram_dq_oe = state == WR_SETUP || state == WR_PULSE || state == WR_HOLD;
        bus.sram_we_n  = state != WR_PULSE;
`ifdef CPU_WAIT_EN
        bus.cpu_wait_n = !cpu_pend;
`else
        bus.cpu_wait_n = 1'b1;
`endif
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: scoreboard bench for sram_arbiter with an async SRAM model and bus monitors.
module tb_sram_arbiter;
    typedef struct {
        logic        wr;
        logic [18:0] addr;
        logic [7:0]  data;
        int          issue;
    } op_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    sram_arbiter_if bus();
    sram_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    logic [7:0] mem [0:(1<<19)-1];
    assign bus.sram_dq_i = mem[bus.sram_addr];
    always @(posedge clk) if (!bus.sram_we_n) mem[bus.sram_addr] <= bus.sram_dq_o;
    int n_tests = 0, n_fail = 0, cyc = 0;
    int n_we_lo = 0, n_wait_lo = 0, n_stray = 0, n_vack = 0, n_rd = 0, n_oe = 0;
    op_t exp_q[$];
    logic [7:0] log_q[$];
    logic [7:0] vid_exp = 8'h00;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // bus monitor: pops the scoreboard when a CPU read or write is seen to complete
    int rd_cnt, wlen, vp;
    logic rd_fin, prev_oe;
    logic [3:0] wseq;
    logic [18:0] waddr, prev_addr;
    logic [7:0] wdata;
    op_t op;
    always @(negedge clk) begin
        if (rst) begin
            rd_cnt = 0; rd_fin = 1'b0; wlen = 0; wseq = 4'h0; vp = 0; prev_oe = 1'b0; prev_addr = '0;
        end else begin
            if (!bus.sram_we_n) n_we_lo++;
            if (!bus.cpu_wait_n) n_wait_lo++;
            if (bus.sram_dq_oe) n_oe++;
            if (bus.sram_addr == 19'h00777) n_stray++;
            if (!bus.sram_dq_oe && bus.sram_addr[18:17] == 2'b00 &&
                (bus.sram_addr[16:14] == 3'b101 || bus.sram_addr[16:14] == 3'b111) &&
                bus.sram_addr != prev_addr && exp_q.size() > 0 && exp_q[0].issue < cyc) vp++;
            if (bus.vid_ack) begin
                check("vid_data", bus.vid_data, vid_exp);
                n_vack++;
                log_q.push_back("V");
            end
            if (rd_fin) begin
                rd_fin = 1'b0;
                op = exp_q.pop_front();
                check("rd_data", bus.cpu_dout, op.data);
                check("rd_latency_le7", cyc - op.issue <= 7, 1);
                check("rd_alternate", vp <= 1, 1);
                vp = 0;
                n_rd++;
                log_q.push_back("C");
            end else if (exp_q.size() > 0 && !exp_q[0].wr && !bus.sram_dq_oe && bus.sram_addr == exp_q[0].addr) begin
                rd_cnt++;
                if (rd_cnt == 2) begin
                    rd_fin = 1'b1;
                    rd_cnt = 0;
                end
            end else begin
                rd_cnt = 0;
            end
            if (bus.sram_dq_oe) begin
                if (wlen == 0) begin
                    waddr = bus.sram_addr;
                    wdata = bus.sram_dq_o;
                end
                wseq = {wseq[2:0], bus.sram_we_n};
                wlen++;
            end else if (prev_oe) begin
                if (exp_q.size() == 0 || !exp_q[0].wr) begin
                    check("wr_unexpected", 1, 0);
                end else begin
                    op = exp_q.pop_front();
                    check("wr_len", wlen, 4);
                    check("wr_we_shape", wseq, 4'b1001);
                    check("wr_addr", waddr, op.addr);
                    check("wr_data", wdata, op.data);
                    check("wr_latency_le7", cyc - op.issue <= 7, 1);
                    check("wr_alternate", vp <= 1, 1);
                    vp = 0;
                end
                wlen = 0;
            end
            prev_oe = bus.sram_dq_oe;
            prev_addr = bus.sram_addr;
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic cpu_op(input logic wr, input logic [18:0] addr, input logic [7:0] data);
        bus.cpu_addr = addr;
        bus.cpu_din  = data;
        bus.cpu_we_n = !wr;
        bus.cpu_oe_n = 1'b0;
        exp_q.push_back('{wr, addr, data, cyc + 1});
        tick();
        bus.cpu_oe_n = 1'b1;
        bus.cpu_we_n = 1'b1;
    endtask
    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) tick();
        check("drain", exp_q.size(), 0);
        exp_q.delete();
    endtask
    task automatic wait_vack(input int base);
        for (int i = 0; i < 12 && n_vack == base; i++) tick();
        check("vid_ack_seen", n_vack > base, 1);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        int v0, r0, oe0;
        logic [15:0] ord;
        bus.cpu_addr = '0; bus.cpu_din = '0; bus.cpu_oe_n = 1'b1; bus.cpu_we_n = 1'b1;
        bus.vid_req = 1'b0; bus.vid_page = 1'b0; bus.vid_addr = '0;
        mem[19'h02A05] <= 8'h5C;
        mem[19'h14100] <= 8'h3E;
        mem[19'h00123] <= 8'h71;
        for (int i = 0; i < 25; i++) mem[19'h00200 + i] <= 8'(i * 7 + 3);
        repeat (3) tick();
        check("rst_cpu_dout", bus.cpu_dout, 8'h00);
        check("rst_vid_data", bus.vid_data, 8'h00);
        check("rst_vid_ack", bus.vid_ack, 0);
        check("rst_we_n", bus.sram_we_n, 1);
        check("rst_dq_oe", bus.sram_dq_oe, 0);
        check("rst_sram_addr", bus.sram_addr, 0);
        check("rst_wait_n", bus.cpu_wait_n, 1);
        rst = 1'b0;
        tick();
        cpu_op(1'b0, 19'h02A05, 8'h5C);
        tick();
        check("rd_addr_c1", bus.sram_addr, 19'h02A05);
        tick();
        check("rd_addr_c2", bus.sram_addr, 19'h02A05);
        tick();
        check("rd_dout", bus.cpu_dout, 8'h5C);
        drain();
        check("rd_no_we", n_we_lo, 0);
        cpu_op(1'b1, 19'h1C000, 8'hA5);
        drain();
        check("wr_mem", mem[19'h1C000], 8'hA5);
        check("wr_we_cycles", n_we_lo, 2);
        vid_exp = 8'h3E; bus.vid_page = 1'b0; bus.vid_addr = 14'h0100; bus.vid_req = 1'b1;
        v0 = n_vack;
        wait_vack(v0);
        bus.vid_req = 1'b0;
        repeat (4) tick();
        log_q.delete();
        vid_exp = 8'hA5; bus.vid_page = 1'b1; bus.vid_addr = 14'h0000; bus.vid_req = 1'b1;
        cpu_op(1'b0, 19'h00123, 8'h71);
        check("coll_vid_addr", bus.sram_addr, 19'h1C000);
        drain();
        bus.vid_req = 1'b0;
        repeat (4) tick();
        ord = log_q.size() >= 2 ? {log_q[0], log_q[1]} : 16'h0;
        check("coll_order", ord, {8'h56, 8'h43});
        cpu_op(1'b0, 19'h02A05, 8'h5C);
        tick();
        bus.cpu_addr = 19'h00777;
        bus.cpu_oe_n = 1'b0;
        tick();
        bus.cpu_oe_n = 1'b1;
        drain();
        repeat (6) tick();
        check("edge_ignored", n_stray, 0);
        vid_exp = 8'h3E; bus.vid_page = 1'b0; bus.vid_addr = 14'h0100; bus.vid_req = 1'b1;
        r0 = n_rd;
        for (int i = 0; i < 25; i++) begin
            cpu_op(1'b0, 19'h00200 + 19'(i), 8'(i * 7 + 3));
            repeat (7) tick();
        end
        drain();
        bus.vid_req = 1'b0;
        repeat (4) tick();
        check("starve_reads", n_rd - r0, 25);
        cpu_op(1'b1, 19'h00400, 8'h66);
        for (int i = 0; i < 10 && bus.sram_we_n; i++) tick();
        check("rst_wr_pulse_seen", bus.sram_we_n, 0);
        rst = 1'b1;
        tick();
        check("rst_mid_we_n", bus.sram_we_n, 1);
        check("rst_mid_dq_oe", bus.sram_dq_oe, 0);
        rst = 1'b0;
        exp_q.delete();
        oe0 = n_oe;
        repeat (10) tick();
        check("rst_abandon", n_oe - oe0, 0);
        cpu_op(1'b0, 19'h02A05, 8'h5C);
        drain();
`ifdef CPU_WAIT_EN
        check("wait_used", n_wait_lo > 0, 1);
`else
        check("wait_tied", n_wait_lo, 0);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
